// File: rtl/seg7_pkg.sv
// Hex glyph table for {g,f,e,d,c,b,a} seven-segment displays, active-high.
// Shared by the nibble decoder and the scanned priority-encoder display.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF  = 7'h00;
  localparam logic [6:0] SEG_DASH = 7'h40;

  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return HEX_GLYPH[nibble];
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble-to-glyph decoder, active-high segments, zero latency.
// No flow control: pure function of the nibble.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/priority_encoder_hex_scan.sv
// Registered priority encoder shown as hex on a multiplexed seven-segment display.
// Index/valid one cycle after capture, segments one more; no backpressure, free-running scan.
module priority_encoder_hex_scan
  import seg7_pkg::*;
#(
  parameter int IN_WIDTH   = 16,
  parameter int DIGITS     = 2,
  parameter int SCAN_DIV   = 1000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IN_WIDTH-1:0]   encoder_in,
  input  logic                  sample_en,
  input  logic                  msb_first,
  input  logic                  enable,
  output logic [4*DIGITS-1:0]   index,
  output logic                  valid,
  output logic [6:0]            segments,
  output logic [DIGITS-1:0]     digit_en
);

  localparam int   IDXW = 4 * DIGITS;
  localparam int   PW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int   PTRW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic POL  = (ACTIVE_LOW != 0);

  logic [IN_WIDTH-1:0] req_q;
  logic                mode_q;
  logic [IDXW-1:0]     win;
  logic [PW-1:0]       prescale;
  logic [PTRW-1:0]     ptr;
  logic [3:0]          nib;
  logic [6:0]          glyph;
  logic [6:0]          seg_hi;
  logic [DIGITS-1:0]   den_hi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q  <= '0;
      mode_q <= 1'b0;
    end else if (sample_en) begin
      req_q  <= encoder_in;
      mode_q <= msb_first;
    end
  end

  // Last match in scan order wins, so scan upward for MSB-first and downward for LSB-first.
  always_comb begin
    win = '0;
    if (mode_q) begin
      for (int i = 0; i < IN_WIDTH; i++)
        if (req_q[i]) win = IDXW'(i);
    end else begin
      for (int i = IN_WIDTH - 1; i >= 0; i--)
        if (req_q[i]) win = IDXW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index <= '0;
      valid <= 1'b0;
    end else begin
      index <= win;
      valid <= |req_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale <= '0;
      ptr      <= '0;
    end else if (prescale == PW'(SCAN_DIV - 1)) begin
      prescale <= '0;
      ptr      <= (ptr == PTRW'(DIGITS - 1)) ? '0 : ptr + 1'b1;
    end else begin
      prescale <= prescale + 1'b1;
    end
  end

  assign nib = 4'(index >> {ptr, 2'b00});

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (nib),
    .seg    (glyph)
  );

  always_comb begin
    seg_hi = SEG_OFF;
    den_hi = '0;
    if (enable) begin
      den_hi = DIGITS'(1) << ptr;
      seg_hi = valid ? glyph : SEG_DASH;
    end
  end

  // Registers hold pin polarity directly so reset shows a dark display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      segments <= {7{POL}};
      digit_en <= {DIGITS{POL}};
    end else begin
      segments <= seg_hi ^ {7{POL}};
      digit_en <= den_hi ^ {DIGITS{POL}};
    end
  end

endmodule

// File: tb/tb_priority_encoder_hex_scan.sv
// Directed bench for priority_encoder_hex_scan with 16 inputs, 2 digits, scan divide 4, active-low pins.
module tb_priority_encoder_hex_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] encoder_in;
  logic        sample_en;
  logic        msb_first;
  logic        enable;
  logic [7:0]  index;
  logic        valid;
  logic [6:0]  segments;
  logic [1:0]  digit_en;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] DIG0 = 2'b10;
  localparam logic [1:0] DIG1 = 2'b01;
  localparam logic [1:0] DARK = 2'b11;

  priority_encoder_hex_scan #(
    .IN_WIDTH(16), .DIGITS(2), .SCAN_DIV(4), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .encoder_in(encoder_in), .sample_en(sample_en),
    .msb_first(msb_first), .enable(enable), .index(index), .valid(valid),
    .segments(segments), .digit_en(digit_en)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bounded wait for a given digit select, then compare the lit segments.
  task automatic check_digit(input string tag, input logic [1:0] sel, input logic [6:0] exp_seg);
    for (int n = 0; n < 20 && digit_en !== sel; n++) @(negedge clk);
    check_eq({tag, "_sel"}, 32'(digit_en), 32'(sel));
    check_eq({tag, "_seg"}, 32'(segments), 32'(exp_seg));
  endtask

  // Capture a vector with one sample pulse and wait until the display reflects it.
  task automatic capture(input logic [15:0] vec, input logic msb);
    encoder_in = vec;
    msb_first  = msb;
    sample_en  = 1'b1;
    @(negedge clk);
    sample_en  = 1'b0;
    @(negedge clk);
  endtask

  // Sync to the first cycle that digit 0 is lit after digit 1.
  task automatic sync_digit0;
    logic [1:0] prev;
    prev = digit_en;
    @(negedge clk);
    for (int n = 0; n < 20 && !(prev == DIG1 && digit_en == DIG0); n++) begin
      prev = digit_en;
      @(negedge clk);
    end
    check_eq("sync_d0", 32'(digit_en), 32'(DIG0));
  endtask

  task automatic check_scan_after_release(input string tag);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq({tag, "_d0_hold"}, 32'(digit_en), 32'(DIG0));
    end
    @(negedge clk);
    check_eq({tag, "_d1_first"}, 32'(digit_en), 32'(DIG1));
  endtask

  typedef struct {
    logic [15:0] vec;
    logic        msb;
    logic [7:0]  idx;
    logic [6:0]  seg0;
  } vec_t;

  vec_t tbl [6] = '{
    '{16'h8120, 1'b0, 8'h05, 7'h12},
    '{16'h8120, 1'b1, 8'h0F, 7'h0E},
    '{16'h0001, 1'b1, 8'h00, 7'h40},
    '{16'h0300, 1'b0, 8'h08, 7'h00},
    '{16'h0300, 1'b1, 8'h09, 7'h10},
    '{16'h4000, 1'b0, 8'h0E, 7'h06}
  };

  initial begin
    rst_n = 1'b0; encoder_in = '0; sample_en = 1'b0; msb_first = 1'b0; enable = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_seg", 32'(segments), 32'h7F);
    check_eq("rst_den", 32'(digit_en), 32'(DARK));
    check_eq("rst_idx", 32'(index), 32'h0);
    check_eq("rst_vld", 32'(valid), 32'h0);

    check_scan_after_release("rel");
    repeat (3) @(negedge clk);
    check_eq("d1_hold_end", 32'(digit_en), 32'(DIG1));
    @(negedge clk);
    check_eq("d0_again", 32'(digit_en), 32'(DIG0));
    check_eq("dash_idle", 32'(segments), 32'h3F);

    // Index/valid are checked one edge after the capture edge, segments a cycle later.
    foreach (tbl[k]) begin
      capture(tbl[k].vec, tbl[k].msb);
      check_eq($sformatf("idx%0d", k), 32'(index), 32'(tbl[k].idx));
      check_eq($sformatf("vld%0d", k), 32'(valid), 32'h1);
      @(negedge clk);
      check_digit($sformatf("v%0d_d0", k), DIG0, tbl[k].seg0);
      check_digit($sformatf("v%0d_d1", k), DIG1, 7'h40);
    end

    // Input and mode changes without a sample pulse must not reach the index.
    encoder_in = 16'hFFFF; msb_first = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("hold_idx", 32'(index), 32'h0E);
    check_eq("hold_vld", 32'(valid), 32'h1);

    capture(16'h0000, 1'b0);
    check_eq("empty_vld", 32'(valid), 32'h0);
    check_eq("empty_idx", 32'(index), 32'h0);
    @(negedge clk);
    check_digit("empty_d0", DIG0, 7'h3F);
    check_digit("empty_d1", DIG1, 7'h3F);

    capture(16'h0040, 1'b0);
    @(negedge clk);
    sync_digit0();
    enable = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      check_eq($sformatf("dis_den%0d", i), 32'(digit_en), 32'(DARK));
      check_eq($sformatf("dis_seg%0d", i), 32'(segments), 32'h7F);
    end
    enable = 1'b1;
    @(negedge clk);
    check_eq("reen_den", 32'(digit_en), 32'(DIG1));
    check_eq("reen_seg", 32'(segments), 32'h40);
    @(negedge clk);
    check_eq("reen_next_den", 32'(digit_en), 32'(DIG0));
    check_eq("reen_next_seg", 32'(segments), 32'h02);

    // Five cycles after the digit 0 switch the scan sits at ptr=1, prescaler=2.
    sync_digit0();
    repeat (5) @(negedge clk);
    check_eq("pre_rst_den", 32'(digit_en), 32'(DIG1));
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_seg", 32'(segments), 32'h7F);
    check_eq("arst_den", 32'(digit_en), 32'(DARK));
    check_eq("arst_idx", 32'(index), 32'h0);
    check_eq("arst_vld", 32'(valid), 32'h0);
    @(negedge clk);
    check_scan_after_release("rel2");
    check_eq("rel2_vld", 32'(valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/priority_encoder_hex_scan.md
# priority_encoder_hex_scan

Parametrised successor to the team's combinational 16-input priority-to-seven-segment coder. It registers a request vector of any width and encodes the winning bit index with a selectable priority direction. It shows that index as hex on a multi-digit, time-multiplexed seven-segment display. It sits between switch or request sources and the board display pins, and also exports the registered index and valid flag for other logic.

## Interface
Parameters:
- IN_WIDTH, 16, number of request inputs (2..256)
- DIGITS, 2, displayed hex digits; must satisfy 4*DIGITS >= clog2(IN_WIDTH)
- SCAN_DIV, 1000, clock cycles each digit is lit (>= 1)
- ACTIVE_LOW, 1, 1 means segments and digit enables are driven inverted (0 = lit)

Ports:
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- encoder_in  in  IN_WIDTH  request vector
- sample_en  in  1  capture encoder_in this cycle
- msb_first  in  1  0: lowest set bit wins; 1: highest set bit wins
- enable  in  1  display enable
- index  out  4*DIGITS  registered winning index, zero-extended
- valid  out  1  registered; 1 if the captured vector had any bit set
- segments  out  7  {g,f,e,d,c,b,a}, polarity per ACTIVE_LOW
- digit_en  out  DIGITS  one-hot digit select, polarity per ACTIVE_LOW; bit 0 is the least significant nibble

## Operation
- Stage 1: when sample_en=1, req_q <= encoder_in and mode_q <= msb_first. Otherwise both hold.
- Stage 2: every cycle, index <= winning bit of req_q per mode_q, and valid <= |req_q. When req_q == 0, index <= 0 and valid <= 0.
- Scan: prescaler counts 0..SCAN_DIV-1. At terminal count it wraps to 0 and digit pointer ptr advances. ptr wraps DIGITS-1 -> 0. The scan runs regardless of enable or sample_en.
- Output stage (registered): digit_en <= onehot(ptr). The segments register loads the glyph for nibble index[4*ptr+3:4*ptr].
- Glyph bit patterns, active-high: 0 3F, 1 06, 2 5B, 3 4F, 4 66, 5 6D, 6 7D, 7 07, 8 7F, 9 6F, A 77, b 7C, C 39, d 5E, E 79, F 71.
- valid=0: every digit shows a dash (40).
- enable=0: segments and digit_en are all unlit. ptr and prescaler keep running.
- Active-low outputs are the bitwise inverse of the above patterns.

## Timing
- Reset values:
  - req_q=0, mode_q=0, index=0, valid=0, prescaler=0, ptr=0.
  - segments and digit_en are all unlit (all 1 when ACTIVE_LOW=1).
- Latency:
  - encoder_in sampled at edge N; index/valid valid after edge N+1.
  - segments reflect the new index after edge N+2, on whichever digit is currently selected.
- sample_en held high: capture every cycle; throughput 1 vector per clock.
- A digit changes every SCAN_DIV cycles. Full refresh period is DIGITS*SCAN_DIV cycles.
- Simultaneous sample and scan advance: each register is independent, and the new ptr pairs with the index present at that edge.
- A msb_first change without sample_en has no effect until the next capture.
- Reset asserted mid-scan: all state returns to reset values immediately (asynchronous). After release, scan restarts at digit 0 with a full SCAN_DIV count.
- SCAN_DIV=1: ptr advances every cycle.
- DIGITS=1: ptr stays 0 and digit_en stays constantly selected.

## Structure
- Shared package seg7_pkg holds:
  - the 16 hex glyph constants
  - SEG_DASH (7'h40) and SEG_OFF (7'h00)
  - a function hex_to_seg(nibble)
- Natural sub-module: hex_to_seg7, a combinational nibble-to-glyph decoder instantiated once for the selected digit.
- Everything else (capture, encoder, scan counter, output register) lives in the top module.

## Test plan
All scenarios use IN_WIDTH=16, DIGITS=2, SCAN_DIV=4, ACTIVE_LOW=1.
- Reset check: hold rst_n=0 -> segments=7'h7F, digit_en=2'b11, index=0, valid=0. Deassert -> digit_en goes to 2'b10 (digit 0 lit) after first output update, then alternates every 4 cycles.
- LSB priority: encoder_in=16'h8120 with msb_first=0 and one sample_en pulse -> index=8'h05, valid=1 two edges later. Digit 0 segments=~7'h6D and digit 1 segments=~7'h3F.
- MSB priority: same vector with msb_first=1 -> index=8'h0F. Digit 0 shows ~7'h71.
- Empty vector: capture 16'h0000 -> valid=0, index=0, and both digits show ~7'h40.
- Enable and hold:
  - enable=0 -> segments=7'h7F, digit_en=2'b11, while ptr keeps toggling; re-enable mid-period -> correct digit shown with no phase reset.
  - Change encoder_in with sample_en=0 -> index unchanged.
- Async reset mid-scan: assert rst_n=0 at prescaler=2, ptr=1 -> outputs unlit within the same cycle. After release, digit 0 is held for exactly 4 cycles.
